core_ctrl: RTL and testbench

//  Multi-cycle sequencer for the single-issue RV32 core datapath (pc, i_mem, decode, register_file, alu).

---
 rtl/core_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// -----------------------------------------------------------------------------
// core_ctrl
// Multi-cycle sequencer for the single-issue RV32 core datapath. It steps each
// instruction through FETCH -> DECODE -> EXEC (-> WB for ALU ops), handshakes
// with instruction memory, resolves conditional branches and drives the PC
// select and register-file write enable. It halts on an illegal instruction or
// when instruction memory does not answer within FETCH_TIMEOUT cycles.
//
// Optional feature macro: CORE_CTRL_PERF_EN
//   defined   : retired_cnt / stall_cnt are saturating performance counters
//   undefined : both counter ports are tied to zero and no counter flops exist
//
// Parameters
//   FETCH_TIMEOUT  cycles allowed in FETCH without imem_ack before fault (>=1)
//   CNT_W          width of the performance counters
//
// Ports
//   clk, reset          clock and asynchronous active-high reset
//   imem_req/imem_ack   instruction fetch handshake
//   ir_load             one-cycle pulse latching the fetched word into the IR
//   is_* / incorrect    decoder flags (sampled at the end of DECODE)
//   valid_rd            instruction writes a destination register
//   rs1_data/rs2_data   register-file read data used for branch compares
//   pc_choice           00 hold, 01 PC+4, 10 PC+imm, 11 PC<=0
//   rf_wr_en            register-file write enable (asserted only in WB)
//   state               current FSM state (debug)
//   halted, fault       sticky stop indication / stop caused by fetch timeout
//   retired_cnt         retired instruction count
//   stall_cnt           FETCH cycles spent waiting for imem_ack
// -----------------------------------------------------------------------------
module core_ctrl #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             is_add,
    input  logic             is_addi,
    input  logic             is_beq,
    input  logic             is_bne,
    input  logic             is_blt,
    input  logic             is_bge,
    input  logic             is_bltu,
    input  logic             is_bgeu,
    input  logic             incorrect,
    input  logic             valid_rd,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic [1:0]       pc_choice,
    output logic             rf_wr_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Branch kind remembered from DECODE so EXEC does not depend on the
    // decoder outputs staying stable.
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } br_t;

    localparam int WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    state_t            state_reg, state_next;
    br_t               br_sel_reg, br_sel_next;
    logic              is_branch_reg, is_branch_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              fault_reg;
    logic              set_fault;
    logic              retire;
    logic              stall_cycle;
    logic              taken;
    logic              any_branch;
    logic              any_op;

    assign any_branch = is_beq | is_bne | is_blt | is_bge | is_bltu | is_bgeu;
    assign any_op     = any_branch | is_add | is_addi;

    always_comb begin
        taken = 1'b0;
        case (br_sel_reg)
            BR_EQ:   taken = (rs1_data == rs2_data);
            BR_NE:   taken = (rs1_data != rs2_data);
            BR_LT:   taken = ($signed(rs1_data) <  $signed(rs2_data));
            BR_GE:   taken = ($signed(rs1_data) >= $signed(rs2_data));
            BR_LTU:  taken = (rs1_data <  rs2_data);
            BR_GEU:  taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RST;
            br_sel_reg    <= BR_EQ;
            is_branch_reg <= 1'b0;
            wait_reg      <= '0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            br_sel_reg    <= br_sel_next;
            is_branch_reg <= is_branch_next;
            wait_reg      <= wait_next;
            if (set_fault) begin
                fault_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        br_sel_next    = br_sel_reg;
        is_branch_next = is_branch_reg;
        wait_next      = '0;          // wait counter is zero on every FETCH entry
        imem_req       = 1'b0;
        ir_load        = 1'b0;
        pc_choice      = 2'b00;
        rf_wr_en       = 1'b0;
        retire         = 1'b0;
        stall_cycle    = 1'b0;
        set_fault      = 1'b0;
        case (state_reg)
            ST_RST: begin
                pc_choice  = 2'b11;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // An ack always wins over a timeout reached in the same cycle.
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end else begin
                    stall_cycle = 1'b1;
                    if (wait_reg == WAIT_LAST) begin
                        state_next = ST_HALT;
                        set_fault  = 1'b1;
                    end else begin
                        wait_next = wait_reg + WAIT_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                if (incorrect || !any_op) begin
                    state_next = ST_HALT;
                end else begin
                    state_next     = ST_EXEC;
                    is_branch_next = any_branch;
                    if (is_beq)       br_sel_next = BR_EQ;
                    else if (is_bne)  br_sel_next = BR_NE;
                    else if (is_blt)  br_sel_next = BR_LT;
                    else if (is_bge)  br_sel_next = BR_GE;
                    else if (is_bltu) br_sel_next = BR_LTU;
                    else              br_sel_next = BR_GEU;
                end
            end
            ST_EXEC: begin
                if (is_branch_reg) begin
                    pc_choice  = taken ? 2'b10 : 2'b01;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                rf_wr_en   = valid_rd;
                pc_choice  = 2'b01;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                // Unused encodings are treated as a corrupted sequencer.
                state_next = ST_HALT;
                set_fault  = 1'b1;
            end
        endcase
    end

    assign state  = state_reg;
    assign halted = (state_reg == ST_HALT);
    assign fault  = fault_reg;

`ifdef CORE_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            if (retire && !(&retired_cnt_reg)) begin
                retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
            end
            if (stall_cycle && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign retired_cnt = retired_cnt_reg;
    assign stall_cnt   = stall_cnt_reg;
`else
    logic unused_perf;
    assign unused_perf = retire ^ stall_cycle;
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;

`ifdef CORE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_load;
    logic        is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu;
    logic        incorrect;
    logic        valid_rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [1:0]  pc_choice;
    logic        rf_wr_en;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    core_ctrl #(.FETCH_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .is_add(is_add), .is_addi(is_addi), .is_beq(is_beq), .is_bne(is_bne),
        .is_blt(is_blt), .is_bge(is_bge), .is_bltu(is_bltu), .is_bgeu(is_bgeu),
        .incorrect(incorrect), .valid_rd(valid_rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc_choice(pc_choice), .rf_wr_en(rf_wr_en), .state(state),
        .halted(halted), .fault(fault),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // op: 0 add, 1 addi, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu, other = none
    task automatic set_op(input int op);
        is_add  = (op == 0);
        is_addi = (op == 1);
        is_beq  = (op == 2);
        is_bne  = (op == 3);
        is_blt  = (op == 4);
        is_bge  = (op == 5);
        is_bltu = (op == 6);
        is_bgeu = (op == 7);
    endtask

    // Ends one ns after the negedge on which reset was released (state RST).
    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b0; incorrect = 1'b0; valid_rd = 1'b0;
        rs1_data = '0; rs2_data = '0; set_op(8);
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (pc_choice !== 2'b11) begin failures++; $display("FAIL rst_pc got=%b exp=11", pc_choice); end
        checks++; if (imem_req !== 1'b0 || ir_load !== 1'b0 || rf_wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_strobes got=%b%b%b exp=000", imem_req, ir_load, rf_wr_en); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin
            failures++; $display("FAIL rst_sticky got=%b%b exp=00", halted, fault); end
        checks++; if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", retired_cnt, stall_cnt); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || pc_choice !== 2'b11) begin
            failures++; $display("FAIL rst_release got=%0d/%b exp=0/11", state, pc_choice); end
        @(negedge clk); imem_ack = 1'b1; #1;
        checks++; if (state !== 3'd1 || imem_req !== 1'b1 || ir_load !== 1'b1) begin
            failures++; $display("FAIL fetch_ack got=%0d/%b/%b exp=1/1/1", state, imem_req, ir_load); end
        @(negedge clk); imem_ack = 1'b0; #1;
        checks++; if (state !== 3'd2 || ir_load !== 1'b0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL decode_entry got=%0d/%b/%b exp=2/0/0", state, ir_load, imem_req); end
        $display("txn reset: release then first fetch acked");
    endtask

    task automatic test_addi();
        logic [2:0] exp_state [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0] exp_pc    [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic       exp_wr    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        set_op(1); valid_rd = 1'b1; incorrect = 1'b0;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); imem_ack = (c == 0); #1;
            checks++;
            if (state !== exp_state[c] || pc_choice !== exp_pc[c] || rf_wr_en !== exp_wr[c]) begin
                failures++;
                $display("FAIL addi_cyc%0d got=%0d/%b/%b exp=%0d/%b/%b", c + 1,
                         state, pc_choice, rf_wr_en, exp_state[c], exp_pc[c], exp_wr[c]);
            end
        end
        @(negedge clk); #1;
        checks++; if (state !== 3'd1 || rf_wr_en !== 1'b0) begin
            failures++; $display("FAIL addi_done got=%0d/%b exp=1/0", state, rf_wr_en); end
        checks++; if (retired_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL addi_retired got=%0d exp=%0d", retired_cnt, PERF ? 1 : 0); end
        $display("txn addi: wb at cycle 4, retired=%0d", retired_cnt);
    endtask

    task automatic test_back_to_back();
        // ADD without a destination register: WB must not write.
        set_op(0); valid_rd = 1'b0;
        imem_ack = 1'b1; #1;
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL b2b_fetch got=%b exp=1", ir_load); end
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (state !== 3'd4 || rf_wr_en !== 1'b0 || pc_choice !== 2'b01) begin
            failures++; $display("FAIL b2b_wb_nord got=%0d/%b/%b exp=4/0/01", state, rf_wr_en, pc_choice); end
        $display("txn add rd=none: no write in wb");
    endtask

    task automatic test_branches();
        int          op_t  [6] = '{4, 6, 2, 3, 5, 7};
        logic [31:0] a_t   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t   [6] = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [1:0]  exp_t [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        valid_rd = 1'b1; incorrect = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(op_t[i]); rs1_data = a_t[i]; rs2_data = b_t[i]; imem_ack = 1'b1; #1;
            checks++; if (state !== 3'd1 || ir_load !== 1'b1) begin
                failures++; $display("FAIL br%0d_fetch got=%0d/%b exp=1/1", i, state, ir_load); end
            @(negedge clk); imem_ack = 1'b0;
            @(negedge clk); #1;
            checks++; if (state !== 3'd3 || pc_choice !== exp_t[i] || rf_wr_en !== 1'b0) begin
                failures++; $display("FAIL br%0d_exec got=%0d/%b/%b exp=3/%b/0", i,
                                     state, pc_choice, rf_wr_en, exp_t[i]); end
            $display("txn branch op=%0d rs1=%h rs2=%h pc_choice=%b", op_t[i], a_t[i], b_t[i], pc_choice);
        end
        @(negedge clk); #1;
        checks++; if (state !== 3'd1 || pc_choice !== 2'b00) begin
            failures++; $display("FAIL br_3cycle got=%0d/%b exp=1/00", state, pc_choice); end
        checks++; if (retired_cnt !== (PERF ? 32'd6 : 32'd0)) begin
            failures++; $display("FAIL br_retired got=%0d exp=%0d", retired_cnt, PERF ? 6 : 0); end
    endtask

    task automatic test_timeout();
        set_op(0);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); imem_ack = 1'b0; #1;
            checks++; if (state !== 3'd1 || imem_req !== 1'b1 || ir_load !== 1'b0) begin
                failures++; $display("FAIL to_wait%0d got=%0d/%b/%b exp=1/1/0", i, state, imem_req, ir_load); end
        end
        @(negedge clk); #1;
        checks++; if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b1) begin
            failures++; $display("FAIL to_halt got=%0d/%b/%b exp=5/1/1", state, halted, fault); end
        checks++; if (stall_cnt !== (PERF ? 32'd4 : 32'd0)) begin
            failures++; $display("FAIL to_stall got=%0d exp=%0d", stall_cnt, PERF ? 4 : 0); end
        imem_ack = 1'b1; #1;
        checks++; if (imem_req !== 1'b0 || ir_load !== 1'b0 || pc_choice !== 2'b00) begin
            failures++; $display("FAIL to_late_ack got=%b/%b/%b exp=0/0/00", imem_req, ir_load, pc_choice); end
        @(negedge clk); imem_ack = 1'b0; #1;
        checks++; if (state !== 3'd5 || fault !== 1'b1) begin
            failures++; $display("FAIL to_sticky got=%0d/%b exp=5/1", state, fault); end
        $display("txn fetch timeout: halted=%b fault=%b stall=%0d", halted, fault, stall_cnt);
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            // k=0: incorrect flag with a valid op; k=1: no op flag at all
            incorrect = (k == 0);
            set_op(k == 0 ? 0 : 8);
            apply_reset();
            @(negedge clk); imem_ack = 1'b1;
            @(negedge clk); imem_ack = 1'b0;
            @(negedge clk); #1;
            checks++; if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b0) begin
                failures++; $display("FAIL ill%0d_halt got=%0d/%b/%b exp=5/1/0", k, state, halted, fault); end
            $display("txn illegal case %0d: halted=%b fault=%b", k, halted, fault);
        end
        incorrect = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        set_op(0); valid_rd = 1'b1;
        apply_reset();
        @(negedge clk); imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk); #1;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL mid_exec got=%0d exp=3", state); end
        reset = 1'b1; #1;
        checks++; if (state !== 3'd0 || pc_choice !== 2'b11 || rf_wr_en !== 1'b0) begin
            failures++; $display("FAIL async_rst got=%0d/%b/%b exp=0/11/0", state, pc_choice, rf_wr_en); end
        @(negedge clk); reset = 1'b0; #1;
        @(negedge clk); #1;
        checks++; if (state !== 3'd1 || rf_wr_en !== 1'b0) begin
            failures++; $display("FAIL post_rst got=%0d/%b exp=1/0", state, rf_wr_en); end
        $display("txn async reset during exec: write dropped");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_branches();
        test_timeout();
        test_illegal();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
